// File: rtl/bip_pkg.sv
// Shared definitions for the BIP processor: word widths, opcodes, selects and
// the decoded control bundle passed from bip_decoder to bip_control.
package bip_pkg;

  localparam int unsigned BIP_NBITS      = 16;
  localparam int unsigned BIP_NB_OPCODE  = 5;
  localparam int unsigned BIP_NB_OPERAND = 11;

  localparam logic [BIP_NB_OPCODE-1:0] OP_HLT  = 5'b00000;
  localparam logic [BIP_NB_OPCODE-1:0] OP_STO  = 5'b00001;
  localparam logic [BIP_NB_OPCODE-1:0] OP_LD   = 5'b00010;
  localparam logic [BIP_NB_OPCODE-1:0] OP_LDI  = 5'b00011;
  localparam logic [BIP_NB_OPCODE-1:0] OP_ADD  = 5'b00100;
  localparam logic [BIP_NB_OPCODE-1:0] OP_ADDI = 5'b00101;
  localparam logic [BIP_NB_OPCODE-1:0] OP_SUB  = 5'b00110;
  localparam logic [BIP_NB_OPCODE-1:0] OP_SUBI = 5'b00111;

  // Accumulator source select encodings
  localparam logic [1:0] SELA_MEM = 2'd0;
  localparam logic [1:0] SELA_IMM = 2'd1;
  localparam logic [1:0] SELA_ALU = 2'd2;

  localparam logic SELB_MEM = 1'b0;
  localparam logic SELB_IMM = 1'b1;
  localparam logic ALU_ADD  = 1'b0;
  localparam logic ALU_SUB  = 1'b1;

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op;
    logic       wr_acc;
    logic       wr_ram;
    logic       rd_ram;
    logic       halt;
  } ctrl_t;

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode decoder; unlisted opcodes decode to an all-zero bundle (NOP).
module bip_decoder
  import bip_pkg::*;
#(
  parameter int unsigned NB_OPCODE = BIP_NB_OPCODE
) (
  input  logic [NB_OPCODE-1:0] opcode,
  output ctrl_t                ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      NB_OPCODE'(OP_HLT):  ctrl.halt = 1'b1;
      NB_OPCODE'(OP_STO):  ctrl.wr_ram = 1'b1;
      NB_OPCODE'(OP_LD): begin
        ctrl.sel_a  = SELA_MEM;
        ctrl.wr_acc = 1'b1;
        ctrl.rd_ram = 1'b1;
      end
      NB_OPCODE'(OP_LDI): begin
        ctrl.sel_a  = SELA_IMM;
        ctrl.wr_acc = 1'b1;
      end
      NB_OPCODE'(OP_ADD): begin
        ctrl.sel_a  = SELA_ALU;
        ctrl.sel_b  = SELB_MEM;
        ctrl.op     = ALU_ADD;
        ctrl.wr_acc = 1'b1;
        ctrl.rd_ram = 1'b1;
      end
      NB_OPCODE'(OP_ADDI): begin
        ctrl.sel_a  = SELA_ALU;
        ctrl.sel_b  = SELB_IMM;
        ctrl.op     = ALU_ADD;
        ctrl.wr_acc = 1'b1;
      end
      NB_OPCODE'(OP_SUB): begin
        ctrl.sel_a  = SELA_ALU;
        ctrl.sel_b  = SELB_MEM;
        ctrl.op     = ALU_SUB;
        ctrl.wr_acc = 1'b1;
        ctrl.rd_ram = 1'b1;
      end
      NB_OPCODE'(OP_SUBI): begin
        ctrl.sel_a  = SELA_ALU;
        ctrl.sel_b  = SELB_IMM;
        ctrl.op     = ALU_SUB;
        ctrl.wr_acc = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/bip_control.sv
// BIP control unit: FETCH/DECODE/EXEC sequencer with PC, IR and cycle counter.
// Strobes are decoded from registered state and gated by i_Enable.
module bip_control
  import bip_pkg::*;
#(
  parameter int unsigned NBITS      = BIP_NBITS,
  parameter int unsigned NB_OPCODE  = BIP_NB_OPCODE,
  parameter int unsigned NB_OPERAND = BIP_NB_OPERAND
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_Enable,
  input  logic [NBITS-1:0]      i_Instruction,
  output logic [NB_OPERAND-1:0] o_PC,
  output logic [NB_OPERAND-1:0] o_Addr,
  output logic [NBITS-1:0]      o_Imm,
  output logic [1:0]            o_SelA,
  output logic                  o_SelB,
  output logic                  o_Op,
  output logic                  o_WrAcc,
  output logic                  o_WrRam,
  output logic                  o_RdRam,
  output logic                  o_Halt,
  output logic [31:0]           o_CycleCount
);

  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_EXEC   = 2'd2;
  localparam logic [1:0] ST_HALT   = 2'd3;

  logic [1:0]            state, state_nxt;
  logic [NB_OPERAND-1:0] pc, pc_nxt;
  logic [NBITS-1:0]      ir, ir_nxt;
  logic [31:0]           cycle_count, count_nxt;
  logic [NB_OPCODE-1:0]  opcode_sel;
  logic                  in_decode;
  ctrl_t                 ctrl;

  // DECODE looks at the live memory word; EXEC uses the latched IR
  assign in_decode  = (state == ST_DECODE);
  assign opcode_sel = in_decode ? i_Instruction[NBITS-1 -: NB_OPCODE]
                                : ir[NBITS-1 -: NB_OPCODE];

  bip_decoder #(
    .NB_OPCODE (NB_OPCODE)
  ) u_decoder (
    .opcode (opcode_sel),
    .ctrl   (ctrl)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= ST_FETCH;
      pc          <= '0;
      ir          <= '0;
      cycle_count <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      ir          <= ir_nxt;
      cycle_count <= count_nxt;
    end
  end

  // Next-state and strobe decode; HLT takes effect in the cycle it is decoded
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    count_nxt = cycle_count;
    o_SelA    = SELA_MEM;
    o_SelB    = 1'b0;
    o_Op      = 1'b0;
    o_WrAcc   = 1'b0;
    o_WrRam   = 1'b0;
    o_RdRam   = 1'b0;
    o_Halt    = (state == ST_HALT) || (in_decode && ctrl.halt);
    if (i_Enable) begin
      case (state)
        ST_FETCH: begin
          state_nxt = ST_DECODE;
          count_nxt = cycle_count + 32'd1;
        end
        ST_DECODE: begin
          ir_nxt  = i_Instruction;
          o_RdRam = ctrl.rd_ram;
          if (ctrl.halt) begin
            state_nxt = ST_HALT;
          end else begin
            state_nxt = ST_EXEC;
            count_nxt = cycle_count + 32'd1;
          end
        end
        ST_EXEC: begin
          o_WrAcc   = ctrl.wr_acc;
          o_WrRam   = ctrl.wr_ram;
          if (ctrl.wr_acc) begin
            o_SelA = ctrl.sel_a;
            o_SelB = ctrl.sel_b;
            o_Op   = ctrl.op;
          end
          pc_nxt    = pc + NB_OPERAND'(1);
          state_nxt = ST_FETCH;
          count_nxt = cycle_count + 32'd1;
        end
        ST_HALT: state_nxt = ST_HALT;
        default: state_nxt = ST_FETCH;
      endcase
    end
  end

  assign o_PC         = pc;
  assign o_Addr       = in_decode ? i_Instruction[NB_OPERAND-1:0] : ir[NB_OPERAND-1:0];
  assign o_Imm        = {{(NBITS-NB_OPERAND){ir[NB_OPERAND-1]}}, ir[NB_OPERAND-1:0]};
  assign o_CycleCount = cycle_count;

endmodule

// File: tb/tb_bip_control.sv
// Directed bench for bip_control: hand-computed expectations checked with
// immediate assertions after each clock step.
module tb_bip_control;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_Enable;
  logic [15:0] i_Instruction;
  logic [10:0] o_PC, o_Addr;
  logic [15:0] o_Imm;
  logic [1:0]  o_SelA;
  logic        o_SelB, o_Op, o_WrAcc, o_WrRam, o_RdRam, o_Halt;
  logic [31:0] o_CycleCount;
  logic [6:0]  strb;

  int errors = 0;
  int checks = 0;

  bip_control dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_Enable      (i_Enable),
    .i_Instruction (i_Instruction),
    .o_PC          (o_PC),
    .o_Addr        (o_Addr),
    .o_Imm         (o_Imm),
    .o_SelA        (o_SelA),
    .o_SelB        (o_SelB),
    .o_Op          (o_Op),
    .o_WrAcc       (o_WrAcc),
    .o_WrRam       (o_WrRam),
    .o_RdRam       (o_RdRam),
    .o_Halt        (o_Halt),
    .o_CycleCount  (o_CycleCount)
  );

  always #5 i_clk = ~i_clk;

  // {SelA[1:0], SelB, Op, WrAcc, WrRam, RdRam}
  assign strb = {o_SelA, o_SelB, o_Op, o_WrAcc, o_WrRam, o_RdRam};

  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
  endtask

  initial begin
    logic any_strobe;
    int   guard;
    i_reset       = 1'b1;
    i_Enable      = 1'b1;
    i_Instruction = 16'h0000;

    // LDI 5 then HLT
    do_reset();
    chk("rst_pc",    32'(o_PC), 32'h0);
    chk("rst_cnt",   o_CycleCount, 32'd0);
    chk("rst_halt",  32'(o_Halt), 32'd0);
    chk("rst_strb",  32'(strb), 32'h00);
    i_Instruction = 16'h1805;
    step();
    chk("ldi_dec_strb", 32'(strb), 32'h00);
    chk("ldi_dec_cnt",  o_CycleCount, 32'd1);
    step();
    chk("ldi_ex_strb",  32'(strb), 32'h24);
    chk("ldi_ex_imm",   32'(o_Imm), 32'h0005);
    chk("ldi_ex_cnt",   o_CycleCount, 32'd2);
    i_Instruction = 16'h0000;
    step();
    chk("hlt_fetch_pc", 32'(o_PC), 32'h1);
    chk("hlt_fetch_strb", 32'(strb), 32'h00);
    step();
    chk("hlt_c5_halt",  32'(o_Halt), 32'd1);
    chk("hlt_c5_cnt",   o_CycleCount, 32'd4);
    step();
    step();
    step();
    chk("hlt_hold_halt", 32'(o_Halt), 32'd1);
    chk("hlt_hold_cnt",  o_CycleCount, 32'd4);
    chk("hlt_hold_pc",   32'(o_PC), 32'h1);
    chk("hlt_hold_strb", 32'(strb), 32'h00);

    // ADD 0x010
    do_reset();
    chk("rst2_halt", 32'(o_Halt), 32'd0);
    i_Instruction = 16'h2010;
    step();
    chk("add_dec_strb", 32'(strb), 32'h01);
    chk("add_dec_addr", 32'(o_Addr), 32'h010);
    step();
    chk("add_ex_strb",  32'(strb), 32'h44);
    chk("add_ex_pc",    32'(o_PC), 32'h0);
    step();
    chk("add_pc_next",  32'(o_PC), 32'h1);

    // SUBI 0x7FF
    i_Instruction = 16'h3FFF;
    step();
    chk("subi_dec_strb", 32'(strb), 32'h00);
    step();
    chk("subi_ex_imm",  32'(o_Imm), 32'hFFFF);
    chk("subi_ex_strb", 32'(strb), 32'h5C);
    step();
    chk("subi_pc_next", 32'(o_PC), 32'h2);
    chk("subi_cnt",     o_CycleCount, 32'd6);

    // STO 0x004 with enable dropped for two edges during EXEC
    i_Instruction = 16'h0804;
    step();
    chk("sto_dec_strb", 32'(strb), 32'h00);
    step();
    chk("sto_ex_strb",  32'(strb), 32'h02);
    chk("sto_ex_addr",  32'(o_Addr), 32'h004);
    chk("sto_ex_cnt",   o_CycleCount, 32'd8);
    i_Enable = 1'b0;
    #1;
    chk("sto_dis0_strb", 32'(strb), 32'h00);
    step();
    chk("sto_dis1_strb", 32'(strb), 32'h00);
    chk("sto_dis1_cnt",  o_CycleCount, 32'd8);
    step();
    chk("sto_dis2_strb", 32'(strb), 32'h00);
    chk("sto_dis2_cnt",  o_CycleCount, 32'd8);
    chk("sto_dis2_pc",   32'(o_PC), 32'h2);
    i_Enable = 1'b1;
    #1;
    chk("sto_reen_strb", 32'(strb), 32'h02);
    step();
    chk("sto_after_strb", 32'(strb), 32'h00);
    chk("sto_after_pc",   32'(o_PC), 32'h3);
    chk("sto_after_cnt",  o_CycleCount, 32'd9);

    // Reset pulsed during DECODE of ADD
    i_Instruction = 16'h2010;
    step();
    chk("rstdec_rd", 32'(o_RdRam), 32'd1);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    chk("rstdec_pc",   32'(o_PC), 32'h0);
    chk("rstdec_cnt",  o_CycleCount, 32'd0);
    chk("rstdec_strb", 32'(strb), 32'h00);
    step();
    chk("rstdec_redec_strb", 32'(strb), 32'h01);

    // NOP stream up to PC wrap
    do_reset();
    i_Instruction = 16'hF800;
    any_strobe = 1'b0;
    guard = 0;
    while (o_PC != 11'h7FF && guard < 7000) begin
      step();
      any_strobe = any_strobe | (|strb);
      guard++;
    end
    chk("nop_reach_7ff", 32'(o_PC), 32'h7FF);
    chk("nop_cnt_7ff",   o_CycleCount, 32'd6141);
    step();
    any_strobe = any_strobe | (|strb);
    step();
    any_strobe = any_strobe | (|strb);
    chk("nop_ex_pc", 32'(o_PC), 32'h7FF);
    step();
    any_strobe = any_strobe | (|strb);
    chk("nop_wrap_pc",  32'(o_PC), 32'h000);
    chk("nop_wrap_cnt", o_CycleCount, 32'd6144);
    chk("nop_no_strb",  32'(any_strobe), 32'd0);
    chk("nop_no_halt",  32'(o_Halt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bip_control.md
BIP_CONTROL -- requirements
Module: bip_control

Interface
REQ-001 Parameter NBITS, default 16, instruction and data word width.
REQ-002 Parameter NB_OPCODE, default 5, opcode field width (instruction bits [NBITS-1 -: NB_OPCODE]).
REQ-003 Parameter NB_OPERAND, default 11, operand field width (instruction bits [NB_OPERAND-1:0]); NB_OPCODE+NB_OPERAND SHALL equal NBITS.
REQ-004 i_clk  in  1  single clock; all state changes on rising edge.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 i_Enable  in  1  run enable; low freezes all state and counters.
REQ-007 i_Instruction  in  NBITS  program-memory read data, valid one cycle after o_PC is presented.
REQ-008 o_PC  out  NB_OPERAND  program-memory address.
REQ-009 o_Addr  out  NB_OPERAND  data-memory address (latched operand).
REQ-010 o_Imm  out  NBITS  operand sign-extended to NBITS.
REQ-011 o_SelA  out  2  accumulator source: 0 data memory, 1 o_Imm, 2 adder/subtractor result.
REQ-012 o_SelB  out  1  adder/subtractor B operand: 0 data memory, 1 o_Imm.
REQ-013 o_Op  out  1  adder/subtractor operation: 0 add, 1 subtract.
REQ-014 o_WrAcc / o_WrRam / o_RdRam  out  1 each  accumulator write, data-memory write, data-memory read strobes.
REQ-015 o_Halt  out  1  processor halted.
REQ-016 o_CycleCount  out  32  cycles executed since reset.

Function
REQ-017 FSM states SHALL be FETCH, DECODE, EXEC, HALT; every non-HLT instruction SHALL take exactly 3 enabled cycles.
REQ-018 FETCH: o_PC holds PC; no strobe asserted; next state DECODE.
REQ-019 DECODE: i_Instruction latched into IR; opcode 00000 (HLT) -> HALT; otherwise -> EXEC; o_RdRam=1 in DECODE for LD and ADD/SUB with memory operand (opcodes 00010, 00100, 00110), o_Addr = operand.
REQ-020 EXEC: decoded strobes asserted for exactly this cycle; PC <= PC+1; next state FETCH.
REQ-021 Decode table (EXEC): STO 00001 -> o_WrRam=1; LD 00010 -> SelA=0, WrAcc=1; LDI 00011 -> SelA=1, WrAcc=1; ADD 00100 -> SelA=2, SelB=0, Op=0, WrAcc=1; ADDI 00101 -> SelA=2, SelB=1, Op=0, WrAcc=1; SUB 00110 -> SelA=2, SelB=0, Op=1, WrAcc=1; SUBI 00111 -> SelA=2, SelB=1, Op=1, WrAcc=1.
REQ-022 Any other opcode SHALL behave as NOP: no strobes, PC advances normally.
REQ-023 All strobes SHALL be 0 outside their specified cycle; o_SelA, o_SelB, o_Op SHALL be 0 when o_WrAcc=0.
REQ-024 o_Imm SHALL be IR operand sign-extended (bit NB_OPERAND-1 replicated), e.g. 0x7FF -> 0xFFFF.
REQ-025 PC SHALL wrap from 2^NB_OPERAND-1 to 0 without flag.
REQ-026 HALT: absorbing until reset; o_Halt=1; PC, IR, o_CycleCount frozen; all strobes 0.
REQ-027 o_CycleCount SHALL increment by 1 on each enabled cycle while not in HALT, wrapping at 2^32.
REQ-028 i_Enable=0 in any state: state, PC, IR, counter held; strobes forced 0; on re-enable the interrupted state resumes and its strobes reassert.

Reset
REQ-029 i_reset=1 at a rising edge SHALL force state FETCH, PC=0, IR=0, o_CycleCount=0, o_Halt=0, all strobes/selects 0, overriding i_Enable.
REQ-030 Reset asserted mid-instruction (DECODE or EXEC) SHALL abort it with no strobe in the following cycle.

Structure
REQ-031 Opcode constants, o_SelA encodings and NBITS/NB_OPCODE/NB_OPERAND defaults SHALL live in a shared package used by bip_control and the datapath.
REQ-032 Opcode-to-control decoding SHALL be a combinational sub-module bip_decoder; bip_control holds FSM, PC, IR and counter.

Verification
REQ-033 Reset then program LDI 5 (0x1805), HLT -> WrAcc=1, SelA=1, o_Imm=0x0005 in cycle 3; o_Halt=1 from cycle 5; o_CycleCount stops at 4.
REQ-034 ADD 0x010 (0x2010) -> o_RdRam=1, o_Addr=0x010 in DECODE; EXEC SelA=2, SelB=0, Op=0, WrAcc=1; PC 0 -> 1.
REQ-035 SUBI 0x7FF (0x3FFF) -> o_Imm=0xFFFF, SelB=1, Op=1, WrAcc=1 in EXEC.
REQ-036 PC preloaded to 0x7FF via NOP stream (opcode 11111) -> after EXEC PC=0x000, no strobes ever asserted.
REQ-037 i_Enable dropped 2 cycles during EXEC of STO 0x004 -> o_WrRam=0 while disabled, asserted once after re-enable, counter advances only on enabled cycles.
REQ-038 i_reset pulsed during DECODE of ADD -> next cycle FETCH, PC=0, no WrAcc, counter=0.
